// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the MAR/MDR memory responder.
package mem_pkg;

    localparam int ADDR_W_DEF      = 9;
    localparam int DATA_W_DEF      = 32;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM; read-old-data on a same-cycle write, registered output.
module ram_sp
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we)
            mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a MAR/MDR request, waits WAIT_CYCLES, accesses RAM,
// then pulses MemDone and holds until the strobe is released.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mdatain,
    output logic              MemDone,
    output logic              MemBusy,
    output logic              MemErr
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // Commit is gated by state, so an async clear before the ACCESS exit edge drops it.
    assign ram_we = (state == ACCESS) && wr_q;

    ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (addr_q),
        .din   (data_q),
        .dout  (ram_dout)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            Mdatain <= '0;
            MemDone <= 1'b0;
            MemBusy <= 1'b0;
            MemErr  <= 1'b0;
        end else begin
            MemDone <= 1'b0;
            MemErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Read && Write) begin
                        MemErr <= 1'b1;
                    end else if (Read || Write) begin
                        addr_q  <= Address;
                        data_q  <= WriteData;
                        wr_q    <= Write;
                        cnt     <= CNT_INIT;
                        MemBusy <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ACCESS;
                end
                ACCESS: state <= DONE;
                DONE: begin
                    // ram_dout was captured at the ACCESS exit edge
                    MemDone <= 1'b1;
                    if (!wr_q)
                        Mdatain <= ram_dout;
                    state <= HOLD;
                end
                HOLD: begin
                    if (!Read && !Write) begin
                        MemBusy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
